// File: rtl/cmult_arbiter_pkg.sv
// Shared types and defaults for the complex-multiplier arbiter slice.
package cmult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_REQ        = 4;
  localparam int DEFAULT_DATA_WIDTH     = 16;
  localparam int DEFAULT_OUTPUT_WIDTH   = 18;
  localparam int DEFAULT_TIMEOUT_CYCLES = 15;
  localparam int OP_COUNT_WIDTH         = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmult_arbiter_if.sv
// Requester-side and multiplier-side buses of the arbiter in one bundle.
// Handshakes: a request transfers when req_valid[i] && req_ready[i] in the same
// cycle; a response transfers when rsp_valid[i] && rsp_ready[i]; once raised,
// rsp_valid and its data hold until that transfer. mul_valid is a one-cycle
// result strobe, and mul_ready reports the multiplier can take a new operation.
interface cmult_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_WIDTH = 18
) ();
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_real;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_imag;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_real;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_imag;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [OUTPUT_WIDTH-1:0]       rsp_real;
  logic [OUTPUT_WIDTH-1:0]       rsp_imag;
  logic                          rsp_err;
  logic                          mul_enable;
  logic [DATA_WIDTH-1:0]         mul_a_real;
  logic [DATA_WIDTH-1:0]         mul_a_imag;
  logic [DATA_WIDTH-1:0]         mul_b_real;
  logic [DATA_WIDTH-1:0]         mul_b_imag;
  logic [OUTPUT_WIDTH-1:0]       mul_result_real;
  logic [OUTPUT_WIDTH-1:0]       mul_result_imag;
  logic                          mul_valid;
  logic                          mul_ready;

  modport slave (
    input  req_valid, req_a_real, req_a_imag, req_b_real, req_b_imag, rsp_ready,
    input  mul_result_real, mul_result_imag, mul_valid, mul_ready,
    output req_ready, rsp_valid, rsp_real, rsp_imag, rsp_err,
    output mul_enable, mul_a_real, mul_a_imag, mul_b_real, mul_b_imag
  );

  modport master (
    output req_valid, req_a_real, req_a_imag, req_b_real, req_b_imag, rsp_ready,
    output mul_result_real, mul_result_imag, mul_valid, mul_ready,
    input  req_ready, rsp_valid, rsp_real, rsp_imag, rsp_err,
    input  mul_enable, mul_a_real, mul_a_imag, mul_b_real, mul_b_imag
  );
endinterface

// File: rtl/cmult_arbiter_rr.sv
// Round-robin selector: search starts one past the last accepted grant.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/cmult_arbiter.sv
// Shares one complex multiplier between NUM_REQ requesters with round-robin
// arbitration, a per-operation watchdog and routed, held responses.
module cmult_arbiter
  import cmult_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int OUTPUT_WIDTH   = DEFAULT_OUTPUT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cmult_arbiter_if.slave            bus,
  output logic                      busy,
  output logic [OP_COUNT_WIDTH-1:0] op_count,
  output logic                      timeout_sticky,
  output state_t                    fsm_state
);
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state;
  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        sel;
  logic [DATA_WIDTH-1:0]   a_re, a_im, b_re, b_im;
  logic [OUTPUT_WIDTH-1:0] rsp_re, rsp_im;
  logic                    rsp_e;
  logic [WD_W-1:0]         wd;
  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    any_req;
  logic                    start;
  logic                    in_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (bus.req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Acceptance is combinational so the winner sees req_ready in its grant cycle.
  assign start         = rst_n && (state == IDLE) && bus.mul_ready && any_req;
  assign bus.req_ready = start ? grant : '0;
  assign in_busy       = (state == BUSY);

  assign bus.mul_enable = in_busy && !bus.mul_valid;
  assign bus.mul_a_real = in_busy ? a_re : '0;
  assign bus.mul_a_imag = in_busy ? a_im : '0;
  assign bus.mul_b_real = in_busy ? b_re : '0;
  assign bus.mul_b_imag = in_busy ? b_im : '0;

  assign bus.rsp_valid = (state == RESP) ? (NUM_REQ'(1) << sel) : '0;
  assign bus.rsp_real  = rsp_re;
  assign bus.rsp_imag  = rsp_im;
  assign bus.rsp_err   = rsp_e;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= IDX_W'(NUM_REQ - 1);
      sel            <= '0;
      a_re           <= '0;
      a_im           <= '0;
      b_re           <= '0;
      b_im           <= '0;
      rsp_re         <= '0;
      rsp_im         <= '0;
      rsp_e          <= 1'b0;
      wd             <= '0;
      op_count       <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= BUSY;
            sel        <= grant_idx;
            last_grant <= grant_idx;
            a_re       <= bus.req_a_real[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            a_im       <= bus.req_a_imag[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            b_re       <= bus.req_b_real[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            b_im       <= bus.req_b_imag[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            wd         <= '0;
          end
        end
        BUSY: begin
          wd <= wd + 1'b1;
          // A result arriving on the expiry cycle still wins over the watchdog.
          if (bus.mul_valid) begin
            state    <= RESP;
            rsp_re   <= bus.mul_result_real;
            rsp_im   <= bus.mul_result_imag;
            rsp_e    <= 1'b0;
            op_count <= op_count + 1'b1;
          end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state          <= RESP;
            rsp_re         <= '0;
            rsp_im         <= '0;
            rsp_e          <= 1'b1;
            timeout_sticky <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[sel]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmult_arbiter.sv
// Self-checking bench for cmult_arbiter with a latency-programmable multiplier
// model and a transaction-level reference for grants and responses.
module tb_cmult_arbiter;
  import cmult_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 18;
  localparam int TO = 15;
  localparam int EW = 2 + OW + OW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy;
  logic [15:0]   op_count;
  logic          timeout_sticky;
  state_t        fsm_state;

  always #5 clk = ~clk;

  cmult_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW)) bus ();

  cmult_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy          (busy),
    .op_count      (op_count),
    .timeout_sticky(timeout_sticky),
    .fsm_state     (fsm_state)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];
  int model_last;
  int op_ar[N], op_ai[N], op_br[N], op_bi[N];

  // Multiplier model: result strobes after mul_lat enabled cycles.
  int mul_cnt   = 0;
  int mul_lat   = 3;
  bit mul_stall = 1'b0;

  always @(posedge clk) begin
    if (bus.mul_enable) mul_cnt <= mul_cnt + 1;
    else                mul_cnt <= 0;
  end

  assign bus.mul_valid = !mul_stall && (mul_cnt == mul_lat);

  always_comb begin
    bus.mul_result_real = OW'(longint'($signed(bus.mul_a_real)) * longint'($signed(bus.mul_b_real))
                            - longint'($signed(bus.mul_a_imag)) * longint'($signed(bus.mul_b_imag)));
    bus.mul_result_imag = OW'(longint'($signed(bus.mul_a_real)) * longint'($signed(bus.mul_b_imag))
                            + longint'($signed(bus.mul_a_imag)) * longint'($signed(bus.mul_b_real)));
  end

  function automatic logic [2*OW-1:0] cprod(input int ar, input int ai, input int br, input int bi);
    longint re, im;
    re = longint'(ar) * br - longint'(ai) * bi;
    im = longint'(ar) * bi + longint'(ai) * br;
    return {OW'(re), OW'(im)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] reqs);
    for (int k = 1; k <= N; k++) begin
      if (((reqs >> ((model_last + k) % N)) & N'(1)) != '0) return (model_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    return (w < 0) ? '0 : (N'(1) << w);
  endfunction

  function automatic logic [EW-1:0] exp_entry(input int w, input logic err);
    return {2'(w), (err ? {(2*OW){1'b0}} : cprod(op_ar[w], op_ai[w], op_br[w], op_bi[w])), err};
  endfunction

  function automatic logic [N+2*OW:0] exp_rsp(input logic [EW-1:0] e);
    return {onehot(int'(e[EW-1 -: 2])), e[2*OW:1], e[0]};
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic set_ops(input int i, input int ar, input int ai, input int br, input int bi);
    op_ar[i] = ar; op_ai[i] = ai; op_br[i] = br; op_bi[i] = bi;
    bus.req_a_real[i*DW +: DW] = DW'(ar);
    bus.req_a_imag[i*DW +: DW] = DW'(ai);
    bus.req_b_real[i*DW +: DW] = DW'(br);
    bus.req_b_imag[i*DW +: DW] = DW'(bi);
  endtask

  task automatic load_ops(input int i);
    set_ops(i, rnd16(), rnd16(), rnd16(), rnd16());
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    bus.mul_ready = 1'b1;
    mul_stall     = 1'b0;
    mul_lat       = 3;
    exp_q.delete();
    model_last    = N - 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    bus.mul_ready = 1'b1;
    for (int i = 0; i < N; i++) load_ops(i);
    @(negedge clk);
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mul_enable, busy, timeout_sticky} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rr=%b rv=%b err=%b en=%b busy=%b st=%b, want all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mul_enable, busy, timeout_sticky);
    end
    vectors++;
    if ({bus.rsp_real, bus.rsp_imag, op_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got re=%h im=%h cnt=%h, want 0", bus.rsp_real, bus.rsp_imag, op_count);
    end
    vectors++;
    if ({bus.mul_a_real, bus.mul_a_imag, bus.mul_b_real, bus.mul_b_imag} !== '0) begin
      miscompares++;
      $display("FAIL reset_mul_ops: got %h, want 0",
               {bus.mul_a_real, bus.mul_a_imag, bus.mul_b_real, bus.mul_b_imag});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready);
    end
  endtask

  task automatic test_single();
    logic exp_en;
    logic [N-1:0] exp_rv;
    do_reset();
    set_ops(2, 3, 4, 5, -2);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_grant: got %b want 0100", bus.req_ready);
    end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1 bus.req_valid = '0;
      @(negedge clk);
      exp_en = (c <= 3);
      exp_rv = (c == 5) ? 4'b0100 : 4'b0000;
      vectors++;
      if ({bus.mul_enable, bus.rsp_valid} !== {exp_en, exp_rv}) begin
        miscompares++;
        $display("FAIL single_timing c=%0d: got en=%b rv=%b want en=%b rv=%b",
                 c, bus.mul_enable, bus.rsp_valid, exp_en, exp_rv);
      end
      if (c == 1) begin
        vectors++;
        if ({bus.mul_a_real, bus.mul_a_imag, bus.mul_b_real, bus.mul_b_imag} !== 64'h0003_0004_0005_fffe) begin
          miscompares++;
          $display("FAIL single_mul_ops: got %h want 0003_0004_0005_fffe",
                   {bus.mul_a_real, bus.mul_a_imag, bus.mul_b_real, bus.mul_b_imag});
        end
      end
      if (c == 5) begin
        vectors++;
        if ({bus.rsp_real, bus.rsp_imag, bus.rsp_err, op_count} !== {18'd23, 18'd14, 1'b0, 16'd1}) begin
          miscompares++;
          $display("FAIL single_result: got re=%0d im=%0d err=%b cnt=%0d want 23 14 0 1",
                   bus.rsp_real, bus.rsp_imag, bus.rsp_err, op_count);
        end
      end
      if (c == 6) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL single_idle: got busy=%b want 0", busy);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int cnt[N];
    int done, w;
    logic [N-1:0] exp_rr;
    logic [EW-1:0] f;
    do_reset();
    for (int i = 0; i < N; i++) begin load_ops(i); cnt[i] = 0; end
    bus.req_valid = '1;
    done = 0;
    for (int cyc = 0; cyc < 200 && done < 8; cyc++) begin
      @(negedge clk);
      w = (exp_q.size() == 0) ? rr_pick(bus.req_valid) : -1;
      exp_rr = onehot(w);
      vectors++;
      if (bus.req_ready !== exp_rr) begin
        miscompares++;
        $display("FAIL rr_grant cyc=%0d: got %b want %b", cyc, bus.req_ready, exp_rr);
      end
      if (w >= 0) begin
        exp_q.push_back(exp_entry(w, 1'b0));
        model_last = w;
        order.push_back(w);
        cnt[w]++;
      end
      if (bus.rsp_valid != '0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rr_rsp_unexpected: got rv=%b want none", bus.rsp_valid);
        end else begin
          f = exp_q.pop_front();
          if ({bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err} !== exp_rsp(f)) begin
            miscompares++;
            $display("FAIL rr_rsp: got %h want %h",
                     {bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err}, exp_rsp(f));
          end
          done++;
        end
      end
      @(posedge clk);
      #1;
      if (w >= 0) load_ops(w);
    end
    vectors++;
    if (done != 8) begin
      miscompares++;
      $display("FAIL rr_completions: got %0d want 8", done);
    end
    for (int i = 0; i < order.size() && i < 5; i++) begin
      vectors++;
      if (order[i] != i % N) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % N);
      end
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (cnt[i] != 2) begin
        miscompares++;
        $display("FAIL rr_starve[%0d]: got %0d grants want 2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e;
    bit seen;
    do_reset();
    for (int i = 0; i < N; i++) load_ops(i);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 4'b1101;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_grant: got %b want 0010", bus.req_ready);
    end
    e = exp_entry(1, 1'b0);
    model_last = 1;
    @(posedge clk);
    #1 bus.req_valid = 4'b1101;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL bp_rsp_timeout: got no rsp_valid want 0010 within 20 cycles");
    end
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if ({bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err, busy, bus.req_ready} !== {exp_rsp(e), 1'b1, 4'b0000}) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d: got %h busy=%b rr=%b want %h busy=1 rr=0000", c,
                 {bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err}, busy, bus.req_ready, exp_rsp(e));
      end
      @(posedge clk);
      #1 bus.rsp_ready = 4'($urandom) & 4'b1101;
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 4'b0010;
    @(negedge clk);
    vectors++;
    if ({bus.rsp_valid, bus.req_ready} !== {4'b0010, 4'b0000}) begin
      miscompares++;
      $display("FAIL bp_accept_cycle: got rv=%b rr=%b want 0010 0000", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({bus.rsp_valid, bus.req_ready} !== {4'b0000, onehot(rr_pick(bus.req_valid))}) begin
      miscompares++;
      $display("FAIL bp_next_grant: got rv=%b rr=%b want 0000 %b",
               bus.rsp_valid, bus.req_ready, onehot(rr_pick(bus.req_valid)));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    load_ops(0);
    bus.req_valid = 4'b0001;
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({busy, op_count} !== {1'b0, 16'd1}) begin
      miscompares++;
      $display("FAIL to_setup: got busy=%b cnt=%0d want 0 1", busy, op_count);
    end
    mul_stall = 1'b1;
    load_ops(1);
    @(posedge clk);
    #1 bus.req_valid = 4'b0010;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL to_grant: got %b want 0010", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(posedge clk);
      @(negedge clk);
      if (c <= 15) begin
        vectors++;
        if ({busy, bus.mul_enable, bus.rsp_valid} !== {1'b1, 1'b1, 4'b0000}) begin
          miscompares++;
          $display("FAIL to_busy c=%0d: got busy=%b en=%b rv=%b want 1 1 0000",
                   c, busy, bus.mul_enable, bus.rsp_valid);
        end
      end else begin
        vectors++;
        if ({bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err, timeout_sticky, op_count}
            !== {4'b0010, 36'd0, 1'b1, 1'b1, 16'd1}) begin
          miscompares++;
          $display("FAIL to_rsp: got rv=%b re=%h im=%h err=%b st=%b cnt=%0d want 0010 0 0 1 1 1",
                   bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err, timeout_sticky, op_count);
        end
      end
    end
    mul_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({busy, timeout_sticky} !== 2'b01) begin
      miscompares++;
      $display("FAIL to_sticky_hold: got busy=%b st=%b want 0 1", busy, timeout_sticky);
    end
  endtask

  task automatic test_timeout_race();
    logic [EW-1:0] e;
    do_reset();
    mul_lat = TO - 1;
    load_ops(3);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL race_grant: got %b want 1000", bus.req_ready);
    end
    e = exp_entry(3, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err, timeout_sticky, op_count}
        !== {exp_rsp(e), 1'b0, 16'd1}) begin
      miscompares++;
      $display("FAIL race_rsp: got %h st=%b cnt=%0d want %h st=0 cnt=1",
               {bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err}, timeout_sticky, op_count, exp_rsp(e));
    end
    mul_lat = 3;
  endtask

  task automatic test_reset_mid_op();
    logic [EW-1:0] e;
    bit seen;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 100 + i, 7, -9, 11);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL rmo_grant: got %b want 0100", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, bus.mul_enable, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.mul_a_real, bus.mul_b_imag} !== '0) begin
      miscompares++;
      $display("FAIL rmo_async: got busy=%b en=%b rv=%b rr=%b err=%b a=%h b=%h want all 0",
               busy, bus.mul_enable, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.mul_a_real, bus.mul_b_imag);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = N - 1;
    bus.req_valid = 4'b0111;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rmo_regrant: got %b want 0001", bus.req_ready);
    end
    e = exp_entry(0, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if ({bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err} !== exp_rsp(e) || !seen) begin
      miscompares++;
      $display("FAIL rmo_rsp: got %h seen=%b want %h",
               {bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err}, seen, exp_rsp(e));
    end
  endtask

  task automatic test_mul_ready_low();
    do_reset();
    bus.mul_ready = 1'b0;
    bus.req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.req_ready, busy} !== 5'b0) begin
        miscompares++;
        $display("FAIL mrl_hold c=%0d: got rr=%b busy=%b want 0000 0", c, bus.req_ready, busy);
      end
      @(posedge clk);
      #1;
    end
    bus.mul_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL mrl_release: got %b want 0001", bus.req_ready);
    end
  endtask

  task automatic test_random();
    int w, wait_cyc, served;
    logic [N-1:0] exp_rr;
    logic [EW-1:0] f;
    do_reset();
    for (int i = 0; i < N; i++) load_ops(i);
    wait_cyc = 0;
    served = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.req_valid = 4'($urandom);
      bus.mul_ready = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = 4'($urandom);
      load_ops(int'($urandom_range(0, N - 1)));
      @(negedge clk);
      w = (exp_q.size() == 0 && bus.mul_ready) ? rr_pick(bus.req_valid) : -1;
      exp_rr = onehot(w);
      vectors++;
      if (bus.req_ready !== exp_rr) begin
        miscompares++;
        $display("FAIL rnd_grant cyc=%0d: got %b want %b", cyc, bus.req_ready, exp_rr);
      end
      if (w >= 0) begin
        exp_q.push_back(exp_entry(w, 1'b0));
        model_last = w;
        mul_lat = int'($urandom_range(1, 6));
        wait_cyc = 0;
      end
      if (bus.rsp_valid != '0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_rsp_unexpected cyc=%0d: got rv=%b want none", cyc, bus.rsp_valid);
        end else begin
          f = exp_q[0];
          if ({bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err} !== exp_rsp(f)) begin
            miscompares++;
            $display("FAIL rnd_rsp cyc=%0d: got %h want %h", cyc,
                     {bus.rsp_valid, bus.rsp_real, bus.rsp_imag, bus.rsp_err}, exp_rsp(f));
          end
          if ((bus.rsp_ready & bus.rsp_valid) != '0) begin
            void'(exp_q.pop_front());
            served++;
          end
        end
      end else if (exp_q.size() != 0 && w < 0) begin
        wait_cyc++;
        if (wait_cyc > 12) begin
          vectors++;
          miscompares++;
          $display("FAIL rnd_rsp_missing cyc=%0d: got no rsp_valid want one within 12 cycles", cyc);
          exp_q.delete();
          wait_cyc = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (served < 20) begin
      miscompares++;
      $display("FAIL rnd_throughput: got %0d responses want at least 20", served);
    end
  endtask

  initial begin
    #300000;
    miscompares++;
    $display("FAIL global_timeout: got no finish by 300000 ns want finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_timeout_race();
    test_reset_mid_op();
    test_mul_ready_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmult_arbiter.md
CMULT_ARBITER -- requirements
Module: cmult_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one complex multiplier.
REQ-002 Parameter DATA_WIDTH, default 16: operand width per real/imag part.
REQ-003 Parameter OUTPUT_WIDTH, default 18: result width per real/imag part.
REQ-004 Parameter TIMEOUT_CYCLES, default 15: maximum BUSY cycles allowed without mul_valid.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester operation request.
REQ-008 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-009 req_a_real, req_a_imag, req_b_real, req_b_imag  in  NUM_REQ*DATA_WIDTH each  packed operands; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 rsp_valid  out  NUM_REQ  one-hot result valid, routed to the originating requester.
REQ-011 rsp_ready  in  NUM_REQ  per-requester result accept.
REQ-012 rsp_real, rsp_imag  out  OUTPUT_WIDTH each  shared result bus.
REQ-013 rsp_err  out  1  result invalid because of a timeout; qualified by rsp_valid.
REQ-014 mul_enable  out  1  multiplier enable.
REQ-015 mul_a_real, mul_a_imag, mul_b_real, mul_b_imag  out  DATA_WIDTH each  multiplier operands.
REQ-016 mul_result_real, mul_result_imag  in  OUTPUT_WIDTH each  multiplier results.
REQ-017 mul_valid, mul_ready  in  1 each  multiplier result strobe and idle indication.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 op_count  out  16  count of completed non-error operations; wraps from 0xFFFF to 0.
REQ-020 timeout_sticky  out  1  set on any timeout; cleared only by reset.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-022 IDLE->BUSY: when any req_valid=1 and mul_ready=1, round-robin select winner w, assert req_ready[w] combinationally that cycle, and register w and its operands.
REQ-023 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ; last_grant updates only on an accepted grant.
REQ-024 In IDLE with mul_ready=0, req_ready SHALL be all zero.
REQ-025 mul_operands SHALL present the registered operands throughout BUSY, and zero in IDLE.
REQ-026 mul_enable SHALL equal (state==BUSY) AND NOT mul_valid, so the multiplier never restarts on the completion cycle.
REQ-027 BUSY->RESP on mul_valid: capture mul_result_* into rsp_real/rsp_imag with rsp_err=0, and increment op_count.
REQ-028 Latency with a 3-cycle multiplier: grant at cycle T, mul_valid at T+4, rsp_valid[w]=1 at T+5.
REQ-029 Watchdog counter SHALL clear on IDLE->BUSY and increment each BUSY cycle.
REQ-030 Watchdog expiry: if the counter reaches TIMEOUT_CYCLES without mul_valid, go to RESP with rsp_real=rsp_imag=0, rsp_err=1 and timeout_sticky=1; op_count does not increment.
REQ-031 Simultaneous expiry and mul_valid: mul_valid SHALL take precedence and the result is delivered normally.
REQ-032 In RESP, rsp_valid[w], rsp_real, rsp_imag and rsp_err SHALL stay stable until rsp_ready[w]=1; the FSM then goes to IDLE.
REQ-033 rsp_ready bits other than w SHALL be ignored.
REQ-034 A new grant SHALL NOT occur in the same cycle as RESP->IDLE; arbitration resumes from IDLE on the following cycle.
REQ-035 A requester that deasserts req_valid before being granted SHALL NOT be served.
REQ-036 A requester that is still granted SHALL keep its position in the round-robin order.

Reset
REQ-037 On rst_n=0 the block SHALL immediately enter IDLE, including when reset asserts mid-operation.
REQ-038 On reset, req_ready, rsp_valid, rsp_real, rsp_imag, rsp_err, mul_enable, mul_operands, busy, op_count, timeout_sticky and the watchdog SHALL be 0.
REQ-039 On reset, last_grant SHALL be NUM_REQ-1, so requester 0 wins first.
REQ-040 Results of an operation interrupted by reset SHALL be discarded.

Structure
REQ-041 Package cmult_pkg SHALL hold the state enum (IDLE, BUSY, RESP), default widths, the TIMEOUT_CYCLES default and the op_count width.
REQ-042 Sub-module rr_arbiter (parameter NUM_REQ) SHALL hold the pointer-rotated priority selection logic, with outputs one-hot grant plus index.
REQ-043 All multiplier-side signals SHALL be driven by this block only.

Verification
REQ-044 Single request: req 2 with a=(3,4), b=(5,-2) -> mul_enable high from T+1 to T+3, then rsp_valid[2] at T+5 with rsp_real=23, rsp_imag=14 and op_count=1.
REQ-045 All four requesting continuously with rsp_ready tied high -> grant order 0,1,2,3,0 and no requester starved.
REQ-046 rsp_ready[1] held low for 10 cycles -> rsp_valid[1] and rsp data stable, busy=1, and no new grant until accept.
REQ-047 Model mul_valid never asserts -> after 15 BUSY cycles rsp_valid[w]=1 with rsp_err=1, timeout_sticky=1 and op_count unchanged.
REQ-048 rst_n pulsed low at T+2 of an operation -> all outputs 0 asynchronously and next grant to requester 0.
REQ-049 mul_ready=0 in IDLE with requests pending -> req_ready=0 until mul_ready=1.
